// File: rtl/cdb_pkg.sv
// Shared CDB widths and the broadcast record seen by wakeup logic and the PRF write port.
package cdb_pkg;

    localparam int unsigned TAG_W  = 6;
    localparam int unsigned DATA_W = 32;

    typedef struct packed {
        logic              valid;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } cdb_bcast_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or above ptr, wrapping, one-hot grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx
);

    localparam int unsigned PTR_W = $clog2(N);
    localparam int unsigned IDX_W = $clog2(2 * N);

    logic [2*N-1:0] req_dbl;
    logic           found;

    // Scanning the doubled vector from ptr makes the wrap-around a straight upward search.
    always_comb begin
        req_dbl   = {req, req};
        found     = 1'b0;
        grant     = '0;
        grant_idx = '0;
        for (int k = 0; k < int'(N); k++) begin
            if (!found && req_dbl[IDX_W'(int'(ptr) + k)]) begin
                found     = 1'b1;
                grant_idx = PTR_W'((int'(ptr) + k) % int'(N));
            end
        end
        if (found) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding register per source, round-robin broadcast of one result per cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4,
    parameter int unsigned TAG_W   = cdb_pkg::TAG_W,
    parameter int unsigned DATA_W  = cdb_pkg::DATA_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [NUM_SRC-1:0]          fu_valid,
    input  logic [NUM_SRC*TAG_W-1:0]    fu_tag,
    input  logic [NUM_SRC*DATA_W-1:0]   fu_data,
    output logic [NUM_SRC-1:0]          fu_ready,
    output logic                        cdb_valid,
    output logic [TAG_W-1:0]            cdb_tag,
    output logic [DATA_W-1:0]           cdb_data,
    output logic [$clog2(NUM_SRC)-1:0]  cdb_src
);

    localparam int unsigned SRC_W = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] hold_valid_q, hold_valid_d;
    logic [TAG_W-1:0]   hold_tag_q  [NUM_SRC];
    logic [TAG_W-1:0]   hold_tag_d  [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_q [NUM_SRC];
    logic [DATA_W-1:0]  hold_data_d [NUM_SRC];
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               cdb_valid_q, cdb_valid_d;
    logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
    logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]   cdb_src_q, cdb_src_d;

    logic [NUM_SRC-1:0] grant;
    logic [NUM_SRC-1:0] accept;
    logic [SRC_W-1:0]   grant_idx;
    logic               bcast;

    rr_arbiter #(
        .N (NUM_SRC)
    ) u_rr_arbiter (
        .req       (hold_valid_q),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A source being granted this cycle frees its slot, so it may refill back-to-back.
    assign fu_ready = ~hold_valid_q | grant;
    assign accept   = fu_valid & fu_ready;
    assign bcast    = (|grant) & ~flush;

    always_comb begin
        hold_valid_d = flush ? '0 : ((hold_valid_q & ~grant) | accept);
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            hold_tag_d[i]  = hold_tag_q[i];
            hold_data_d[i] = hold_data_q[i];
            if (accept[i]) begin
                hold_tag_d[i]  = fu_tag[i*TAG_W +: TAG_W];
                hold_data_d[i] = fu_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = bcast;
        cdb_tag_d   = cdb_tag_q;
        cdb_data_d  = cdb_data_q;
        cdb_src_d   = cdb_src_q;
        if (bcast) begin
            rr_ptr_d   = (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
            cdb_tag_d  = hold_tag_q[grant_idx];
            cdb_data_d = hold_data_q[grant_idx];
            cdb_src_d  = grant_idx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= '0;
            for (int i = 0; i < int'(NUM_SRC); i++) begin
                hold_tag_q[i]  <= '0;
                hold_data_q[i] <= '0;
            end
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_tag_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_data_q  <= hold_data_d;
            rr_ptr_q     <= rr_ptr_d;
            cdb_valid_q  <= cdb_valid_d;
            cdb_tag_q    <= cdb_tag_d;
            cdb_data_q   <= cdb_data_d;
            cdb_src_q    <= cdb_src_d;
        end
    end

    assign cdb_valid = cdb_valid_q;
    assign cdb_tag   = cdb_tag_q;
    assign cdb_data  = cdb_data_q;
    assign cdb_src   = cdb_src_q;

endmodule
